// File: rtl/cci_mpf_prim_ram_sched_pkg.sv
// Shared types for the byte-enable RAM scheduler: FSM states, requester id, requester count.
// Used by cci_mpf_prim_ram_byteena_sched and its read-pipeline sub-module.
package cci_mpf_prim_ram_sched_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_A = 1'b0;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_ram_sched_rd_pipe.sv
// Fixed-latency tracker for read requests: shifts valid/id alongside the RAM read latency
// and reports whether any read is still outstanding.
module cci_mpf_prim_ram_sched_rd_pipe
  import cci_mpf_prim_ram_sched_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id,
  output logic    busy
);

  logic [RD_LATENCY-1:0]    valid_q, valid_d;
  req_id_t [RD_LATENCY-1:0] id_q, id_d;

  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    valid_d[0] = in_valid;
    id_d[0]    = in_id;
    for (int i = 1; i < RD_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  // The output stage still counts as in flight: its data is being delivered this cycle.
  assign out_valid = valid_q[RD_LATENCY-1];
  assign out_id    = id_q[RD_LATENCY-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/cci_mpf_prim_ram_byteena_sched.sv
// Two-requester round-robin front end for a single-port byte-enable RAM, with init sweep and clear.
// Optional CCI_MPF_RAM_SCHED_STATS_EN adds grant_cnt (saturating per-requester transfer counts).
//
// state    | meaning
// ST_INIT  | sweep INIT_VALUE into every entry, no grants
// ST_RUN   | rdy=1, round-robin grant of one request per cycle
// ST_DRAIN | after clear: no grants, wait for in-flight reads, then re-init
module cci_mpf_prim_ram_byteena_sched
  import cci_mpf_prim_ram_sched_pkg::*;
#(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_BYTE_BITS = 8,
  parameter int RD_LATENCY = 1,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int BW = N_DATA_BITS / N_BYTE_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  output logic                           rdy,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_wen,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*BW-1:0]          req_byteena,
  input  logic [NUM_REQ*N_DATA_BITS-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [N_DATA_BITS-1:0]         rsp_rdata,
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
  output logic [NUM_REQ*32-1:0]          grant_cnt,
`endif
  output logic [AW-1:0]                  ram_addr,
  output logic                           ram_wen,
  output logic [BW-1:0]                  ram_byteena,
  output logic [N_DATA_BITS-1:0]         ram_wdata,
  input  logic [N_DATA_BITS-1:0]         ram_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_ENTRIES - 1);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          sweep_arm_q, sweep_arm_d;
  req_id_t       prio_q, prio_d;

  req_id_t gnt_id;
  logic    xfer;
  logic    rd_issue;
  logic    pipe_out_valid;
  req_id_t pipe_out_id;
  logic    rd_busy;

  always_comb begin
    if (req_valid[0] && req_valid[1]) begin
      gnt_id = prio_q;
    end else if (req_valid[1]) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = REQ_A;
    end
  end

  // sweep_arm_q holds off the first init write until one edge after reset release.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    sweep_arm_d = 1'b1;
    prio_d      = prio_q;
    req_ready   = '0;
    xfer        = 1'b0;
    rd_issue    = 1'b0;
    ram_addr    = '0;
    ram_wen     = 1'b0;
    ram_byteena = '0;
    ram_wdata   = '0;

    case (state_q)
      ST_INIT: begin
        if (sweep_arm_q) begin
          ram_wen     = 1'b1;
          ram_byteena = '1;
          ram_wdata   = INIT_VALUE;
          ram_addr    = sweep_q;
          if (sweep_q == LAST_ADDR) begin
            sweep_d = '0;
            state_d = ST_RUN;
          end else begin
            sweep_d = sweep_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        xfer = |req_valid;
        if (xfer) begin
          req_ready[gnt_id] = 1'b1;
          ram_addr          = req_addr[int'(gnt_id)*AW +: AW];
          ram_wen           = req_wen[gnt_id];
          ram_byteena       = req_byteena[int'(gnt_id)*BW +: BW];
          ram_wdata         = req_wdata[int'(gnt_id)*N_DATA_BITS +: N_DATA_BITS];
          rd_issue          = ~req_wen[gnt_id];
          prio_d            = other_req(gnt_id);
        end
        if (clear) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        sweep_d = '0;
        if (!rd_busy) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      sweep_arm_q <= 1'b0;
      prio_q      <= REQ_A;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      sweep_arm_q <= sweep_arm_d;
      prio_q      <= prio_d;
    end
  end

  assign rdy = (state_q == ST_RUN);

  cci_mpf_prim_ram_sched_rd_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (rd_issue),
    .in_id    (gnt_id),
    .out_valid(pipe_out_valid),
    .out_id   (pipe_out_id),
    .busy     (rd_busy)
  );

  always_comb begin
    rsp_valid = '0;
    if (pipe_out_valid) begin
      rsp_valid[pipe_out_id] = 1'b1;
    end
  end

  assign rsp_rdata = ram_rdata;

`ifdef CCI_MPF_RAM_SCHED_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];
  logic [31:0] cnt_d [NUM_REQ];

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (req_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
      grant_cnt[i*32 +: 32] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_ram_byteena_sched.sv
// Scoreboard bench for cci_mpf_prim_ram_byteena_sched with a behavioural RAM and reference memory.
module tb_cci_mpf_prim_ram_byteena_sched;

  localparam int AW  = 5;
  localparam int BW  = 8;
  localparam int DW  = 64;
  localparam int NE  = 32;
  localparam int LAT = 2;
  localparam logic [63:0] INIT_V = 64'h0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          rdy;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [1:0]    req_wen = '0;
  logic [9:0]    req_addr = '0;
  logic [15:0]   req_byteena = '0;
  logic [127:0]  req_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [63:0]   rsp_rdata;
  logic [4:0]    ram_addr;
  logic          ram_wen;
  logic [7:0]    ram_byteena;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
  logic [63:0]   grant_cnt;
  int            exp_cnt [2];
`endif

  always #5 clk = ~clk;

  cci_mpf_prim_ram_byteena_sched #(
    .N_ENTRIES(NE), .N_DATA_BITS(DW), .N_BYTE_BITS(8), .RD_LATENCY(LAT), .INIT_VALUE(INIT_V)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_byteena(req_byteena), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_byteena(ram_byteena),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: registered address then registered data = two-cycle read latency.
  logic [63:0] mem [NE];
  logic [4:0]  ram_a1;
  logic [63:0] ram_rd_q;
  always @(posedge clk) begin
    if (ram_wen)
      for (int b = 0; b < BW; b++)
        if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_a1   <= ram_addr;
    ram_rd_q <= mem[ram_a1];
  end
  assign ram_rdata = ram_rd_q;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_rsp = 0;
  int last_id = -1;
  logic [63:0] last_data = '0;
  int pref = 0;
  logic [63:0] ref_mem [NE];

  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Observer: derives the expected grant from the round-robin rule and records expectations.
  logic [1:0] ob_er;
  int         ob_g;
  logic [4:0] ob_a;
  always @(negedge clk) begin
    if (reset_n) begin
      if (!rdy) begin
        if (req_valid != 2'b00) chk(req_ready == 2'b00, "ready_when_not_run", req_ready, 0);
      end else begin
        if (req_valid == 2'b11) ob_g = pref;
        else ob_g = req_valid[1] ? 1 : 0;
        ob_er = (req_valid == 2'b00) ? 2'b00 : (2'b01 << ob_g);
        chk(req_ready == ob_er, "arb_grant", req_ready, ob_er);
        if (ob_er == 2'b00) begin
          chk(ram_wen == 1'b0, "ram_idle_wen", ram_wen, 0);
        end else begin
          ob_a = req_addr[ob_g*AW +: AW];
          chk(ram_addr == ob_a && ram_wen == req_wen[ob_g], "ram_cmd",
              {ram_wen, ram_addr}, {req_wen[ob_g], ob_a});
          if (req_wen[ob_g]) begin
            chk(ram_byteena == req_byteena[ob_g*BW +: BW] && ram_wdata == req_wdata[ob_g*DW +: DW],
                "ram_wdata", ram_wdata, req_wdata[ob_g*DW +: DW]);
            for (int b = 0; b < BW; b++)
              if (req_byteena[ob_g*BW + b]) ref_mem[ob_a][8*b +: 8] = req_wdata[ob_g*DW + 8*b +: 8];
          end else begin
            expq.push_back('{ob_g, ref_mem[ob_a], cyc + LAT});
          end
          pref = 1 - ob_g;
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
          exp_cnt[ob_g]++;
`endif
        end
        if (clear)
          for (int a = 0; a < NE; a++) ref_mem[a] = INIT_V;
      end
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
      if (clear) begin
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
      end
`endif
    end
  end

  // Monitor: pops one expectation per response strobe.
  always @(negedge clk) begin
    if (reset_n && rsp_valid != 2'b00) begin
      exp_t e;
      n_rsp++;
      if (expq.size() == 0) begin
        chk(1'b0, "rsp_unexpected", rsp_valid, 0);
      end else begin
        e = expq.pop_front();
        chk(rsp_valid == (2'b01 << e.id), "rsp_id", rsp_valid, 2'b01 << e.id);
        chk(rsp_rdata == e.data, "rsp_data", rsp_rdata, e.data);
        chk(cyc == e.due, "rsp_latency", cyc, e.due);
      end
      last_id   = rsp_valid[1] ? 1 : 0;
      last_data = rsp_rdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit v, input bit w, input logic [4:0] a,
                         input logic [7:0] be, input logic [63:0] wd);
    req_valid[id] = v;
    req_wen[id] = w;
    req_addr[id*AW +: AW] = a;
    req_byteena[id*BW +: BW] = be;
    req_wdata[id*DW +: DW] = wd;
  endtask

  task automatic wait_init(output int n_wr, output int n_cyc);
    bit done = 1'b0;
    bit started = 1'b0;
    n_wr = 0;
    n_cyc = 0;
    while (!done && n_cyc < 200) begin
      @(negedge clk);
      n_cyc++;
      if (rdy) begin
        done = 1'b1;
      end else if (ram_wen || started) begin
        started = 1'b1;
        chk(ram_wen && ram_addr == AW'(n_wr) && ram_byteena == 8'hFF && ram_wdata == INIT_V,
            "init_sweep", {ram_wen, ram_byteena, ram_addr}, {1'b1, 8'hFF, AW'(n_wr)});
        n_wr++;
      end
    end
    chk(done, "init_timeout", n_cyc, 0);
    chk(n_wr == NE, "init_write_count", n_wr, NE);
  endtask

  task automatic hold_reset_checks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(rdy == 1'b0 && ram_wen == 1'b0 && rsp_valid == 2'b00, "in_reset",
          {rdy, ram_wen, rsp_valid}, 0);
    end
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      for (int id = 0; id < 2; id++)
        set_req(id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                8'($urandom), {$urandom, $urandom});
      tick();
    end
    req_valid = 2'b00;
    repeat (LAT + 3) tick();
    chk(expq.size() == 0, "rsp_outstanding", expq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nw, nc, n0;
    for (int a = 0; a < NE; a++) ref_mem[a] = INIT_V;
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
`endif
    // Both requesters pending through reset and init: no grant may appear before rdy.
    set_req(0, 1'b1, 1'b0, 5'd0, 8'h00, 64'h0);
    set_req(1, 1'b1, 1'b0, 5'd1, 8'h00, 64'h0);
    hold_reset_checks(3);
    reset_n = 1'b1;
    #1;
    chk(ram_wen == 1'b0, "ram_wen_before_first_edge", ram_wen, 0);
    wait_init(nw, nc);
    chk(nc == NE + 1, "rdy_cycle", nc, NE + 1);
    tick();
    req_valid = 2'b00;
    repeat (LAT + 2) tick();

    // Byte-enable merge over the init value.
    set_req(0, 1'b1, 1'b1, 5'd5, 8'h0F, 64'h1122334455667788);
    tick();
    req_valid = 2'b00;
    set_req(1, 1'b1, 1'b0, 5'd5, 8'h00, 64'h0);
    tick();
    req_valid = 2'b00;
    repeat (LAT + 2) tick();
    chk(last_id == 1 && last_data == 64'h0000000055667788, "byteena_merge", last_data,
        64'h0000000055667788);

    // Continuous contention: grants must alternate A,B,... starting with A.
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, 1'b0, 5'(i), 8'h00, 64'h0);
      set_req(1, 1'b1, 1'b0, 5'(i + 8), 8'h00, 64'h0);
      @(negedge clk);
      chk(req_ready == ((i % 2 == 0) ? 2'b01 : 2'b10), "rr_alternate", req_ready,
          (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00;
    repeat (LAT + 2) tick();
    chk(expq.size() == 0, "rr_drain", expq.size(), 0);

    random_phase(400);

    // Clear with two reads in flight.
    set_req(0, 1'b1, 1'b1, 5'd5, 8'hFF, 64'hDEADBEEFCAFEF00D);
    tick();
    req_valid = 2'b00;
    tick();
    set_req(0, 1'b1, 1'b0, 5'd5, 8'h00, 64'h0);
    set_req(1, 1'b1, 1'b0, 5'd6, 8'h00, 64'h0);
    n0 = n_rsp;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    chk(rdy == 1'b0, "rdy_drop_after_clear", rdy, 0);
    wait_init(nw, nc);
    chk(n_rsp == n0 + 2, "drain_rsp_count", n_rsp, n0 + 2);
    tick();
    set_req(0, 1'b1, 1'b0, 5'd5, 8'h00, 64'h0);
    tick();
    req_valid = 2'b00;
    repeat (LAT + 2) tick();
    chk(last_id == 0 && last_data == INIT_V, "clear_reinit", last_data, INIT_V);

    // Asynchronous reset with reads in flight.
    set_req(0, 1'b1, 1'b0, 5'd1, 8'h00, 64'h0);
    set_req(1, 1'b1, 1'b0, 5'd2, 8'h00, 64'h0);
    tick();
    tick();
    #1;
    reset_n = 1'b0;
    expq.delete();
    pref = 0;
    for (int a = 0; a < NE; a++) ref_mem[a] = INIT_V;
`ifdef CCI_MPF_RAM_SCHED_STATS_EN
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
`endif
    #1;
    chk(rsp_valid == 2'b00 && rdy == 1'b0 && ram_wen == 1'b0 && req_ready == 2'b00,
        "async_reset", {rsp_valid, rdy, ram_wen, req_ready}, 0);
    req_valid = 2'b00;
    hold_reset_checks(3);
    reset_n = 1'b1;
    #1;
    chk(ram_wen == 1'b0, "ram_wen_after_rerelease", ram_wen, 0);
    wait_init(nw, nc);
    chk(nc == NE + 1, "rdy_cycle_after_reset", nc, NE + 1);
    tick();

    random_phase(150);

`ifdef CCI_MPF_RAM_SCHED_STATS_EN
    chk(grant_cnt == {32'(exp_cnt[1]), 32'(exp_cnt[0])}, "grant_cnt_model", grant_cnt,
        {32'(exp_cnt[1]), 32'(exp_cnt[0])});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_init(nw, nc);
    tick();
    for (int i = 0; i < 13; i++) begin
      req_valid = 2'b00;
      set_req(i < 10 ? 0 : 1, 1'b1, 1'b1, 5'(i), 8'hFF, 64'(i));
      tick();
    end
    req_valid = 2'b00;
    tick();
    chk(grant_cnt == {32'd3, 32'd10}, "grant_cnt_directed", grant_cnt, {32'd3, 32'd10});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk(grant_cnt == 64'd0, "grant_cnt_cleared", grant_cnt, 0);
    wait_init(nw, nc);
    tick();
`endif

    chk(expq.size() == 0, "final_queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
